// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD arithmetic blocks.
// Holds the BCD digit width, decimal radix constants, the default operand
// length, the subtractor state encoding and a packed-digit extraction helper.
package bcd_pkg;

  localparam int             DIG_W        = 4;
  localparam logic [3:0]     DIG_MAX      = 4'd9;
  localparam logic [4:0]     RADIX        = 5'd10;
  localparam int             NDIG_DEFAULT = 4;
  // Widest operand the extraction helper can index; callers zero-pad up to it.
  localparam int             MAX_NDIG     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Return digit number idx of a zero-padded packed BCD vector (digit 0 in [3:0]).
  function automatic logic [DIG_W-1:0] get_digit(input logic [DIG_W*MAX_NDIG-1:0] v,
                                                 input int idx);
    logic [DIG_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_NDIG; k++) begin
      if (idx == k) r = v[k*DIG_W +: DIG_W];
      else          r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtractor: d = x - y - bin, corrected into
// 0..9 with a borrow out.
// Ports: x, y  - BCD digits (0..9)
//        bin   - borrow in
//        d     - BCD result digit
//        bout  - borrow out
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] x,
  input  logic [DIG_W-1:0] y,
  input  logic             bin,
  output logic [DIG_W-1:0] d,
  output logic             bout
);

  // Raw difference spans -10..9, so 5-bit two's complement is enough;
  // bit 4 is the sign.
  logic [4:0] t_s;

  // Subtract and apply the decimal correction when the raw result is negative.
  always_comb begin
    t_s = 5'(x) - 5'(y) - 5'(bin);
    if (t_s[4]) begin
      d    = 4'(t_s + RADIX);
      bout = 1'b1;
    end else begin
      d    = t_s[3:0];
      bout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial NDIG-digit BCD subtractor producing sign + magnitude of A - B.
// SUB pass walks the digits LSD first; if it ends with a borrow the result is
// negative and a FIX pass replaces diff with its ten's complement.
// Ports: clk, reset (sync, active-high), start (sampled when idle),
//        a, b (packed BCD operands), busy, done (1-cycle pulse),
//        diff (|A-B| packed BCD), neg (A<B), invalid (non-BCD input digit).
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIG_W*NDIG-1:0] a,
  input  logic [DIG_W*NDIG-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DIG_W*NDIG-1:0] diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    borrow_q, borrow_d;
  logic [DIG_W*NDIG-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic                    neg_q, neg_d, invalid_q, invalid_d;
  logic                    busy_q, busy_d, done_q, done_d;
  // An accepted operation with a non-BCD digit waits one cycle in IDLE
  // before reporting, so invalid has a one-cycle latency like a real op.
  logic                    inv_pend_q, inv_pend_d;

  logic [DIG_W*MAX_NDIG-1:0] a_pad_s, b_pad_s, diff_pad_s;
  logic [DIG_W-1:0]          x_s, y_s, d_s;
  logic                      bout_s, last_s, in_bad_s;

  // Zero-pad operands to the helper's fixed width.
  always_comb begin
    a_pad_s    = '0;
    b_pad_s    = '0;
    diff_pad_s = '0;
    a_pad_s[DIG_W*NDIG-1:0]    = a_q;
    b_pad_s[DIG_W*NDIG-1:0]    = b_q;
    diff_pad_s[DIG_W*NDIG-1:0] = diff_q;
  end

  // Flag any non-BCD digit on the live inputs (checked at acceptance).
  always_comb begin
    in_bad_s = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if ((a[k*DIG_W +: DIG_W] > DIG_MAX) || (b[k*DIG_W +: DIG_W] > DIG_MAX)) in_bad_s = 1'b1;
      else                                                                    in_bad_s = in_bad_s;
    end
  end

  // Operand mux: SUB uses (a_i, b_i); FIX computes 0 - diff_i.
  always_comb begin
    if (state_q == ST_FIX) begin
      x_s = '0;
      y_s = get_digit(diff_pad_s, int'(idx_q));
    end else begin
      x_s = get_digit(a_pad_s, int'(idx_q));
      y_s = get_digit(b_pad_s, int'(idx_q));
    end
  end

  bcd_digit_sub u_digit_sub (
    .x    (x_s),
    .y    (y_s),
    .bin  (borrow_q),
    .d    (d_s),
    .bout (bout_s)
  );

  assign last_s = (idx_q == IDX_W'(NDIG - 1));

  // Next-state and result update logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    borrow_d   = borrow_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    neg_d      = neg_q;
    invalid_d  = invalid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    inv_pend_d = inv_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (inv_pend_q) begin
          invalid_d  = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          inv_pend_d = 1'b0;
        end else if (start && !busy_q) begin
          a_d       = a;
          b_d       = b;
          diff_d    = '0;
          neg_d     = 1'b0;
          invalid_d = 1'b0;
          busy_d    = 1'b1;
          if (in_bad_s) begin
            inv_pend_d = 1'b1;
          end else begin
            state_d  = ST_SUB;
            idx_d    = '0;
            borrow_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SUB, ST_FIX: begin
        for (int k = 0; k < NDIG; k++) begin
          if (k == int'(idx_q)) diff_d[k*DIG_W +: DIG_W] = d_s;
          else                  diff_d[k*DIG_W +: DIG_W] = diff_d[k*DIG_W +: DIG_W];
        end
        borrow_d = bout_s;
        if (!last_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else if ((state_q == ST_SUB) && bout_s) begin
          // Final borrow out of the SUB pass means A < B.
          neg_d    = 1'b1;
          state_d  = ST_FIX;
          idx_d    = '0;
          borrow_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      neg_q      <= 1'b0;
      invalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      borrow_q   <= borrow_d;
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      neg_q      <= neg_d;
      invalid_q  <= invalid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign diff    = diff_q;
  assign neg     = neg_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor: an integer-arithmetic model
// predicts busy/done/result every cycle; directed operations pin literal
// results and latencies; a randomized phase exercises starts, resets and
// non-BCD inputs.
module tb_bcd_serial_subtractor;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;

  int n_pass = 0;
  int n_tot  = 0;

  // model state
  logic         m_busy = 1'b0, m_done = 1'b0, m_neg = 1'b0, m_inv = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         p_neg, p_inv;
  logic [W-1:0] p_diff;
  int           m_cnt = 0;

  bcd_serial_subtractor #(.NDIG(NDIG)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .neg(neg), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    logic [W-1:0] t;
    for (int i = NDIG - 1; i >= 0; i--) begin
      t = v >> (4 * i);
      r = r * 10 + int'(t[3:0]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r = '0;
    int y = x;
    for (int i = 0; i < NDIG; i++) begin
      r = r | (W'(y % 10) << (4 * i));
      y = y / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    logic [W-1:0] t;
    logic bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      t = v >> (4 * i);
      if (t[3:0] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Reference model: result from integer arithmetic, completion after a
  // latency of 1 (invalid), NDIG (A>=B) or 2*NDIG (A<B) cycles.
  initial begin
    int va, vb;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_neg = 1'b0; m_inv = 1'b0; m_cnt = 0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 1'b0; m_done = 1'b1;
            m_diff = p_diff; m_neg = p_neg; m_inv = p_inv;
          end
        end else if (start) begin
          va = bcd2int(a);
          vb = bcd2int(b);
          if (has_bad(a) || has_bad(b)) begin
            p_inv = 1'b1; p_neg = 1'b0; p_diff = '0; m_cnt = 1;
          end else begin
            p_inv  = 1'b0;
            p_neg  = (va < vb);
            p_diff = int2bcd(p_neg ? vb - va : va - vb);
            m_cnt  = p_neg ? 2 * NDIG : NDIG;
          end
          m_busy = 1'b1; m_diff = '0; m_neg = 1'b0; m_inv = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare against the model; results only while not busy.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        chk("diff", 32'(diff), 32'(m_diff));
        chk("neg", 32'(neg), 32'(m_neg));
        chk("invalid", 32'(invalid), 32'(m_inv));
      end else begin
        chk("invalid_busy", 32'(invalid), 32'd0);
      end
    end
  end

  // Launch one op, wait for done, check literal latency/result and optional
  // intermediate diff after the SUB pass. disturb re-pulses start with new
  // operands while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] e_diff, input logic e_neg, input logic e_inv,
                        input int e_lat, input logic [W-1:0] e_mid, input logic disturb);
    int lat = 0;
    @(posedge clk); #1;
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 2) begin start = 1'b1; a = 16'h9999; b = 16'h1234; end
      if (disturb && k == 3) start = 1'b0;
      if (e_lat == 2 * NDIG && k == NDIG) chk("mid_diff", 32'(diff), 32'(e_mid));
      if (done) begin lat = k; break; end
    end
    chk("latency", lat, e_lat);
    chk("lit_diff", 32'(diff), 32'(e_diff));
    chk("lit_neg", 32'(neg), 32'(e_neg));
    chk("lit_inv", 32'(invalid), 32'(e_inv));
    chk("model_diff", 32'(m_diff), 32'(e_diff));
    chk("model_neg", 32'(m_neg), 32'(e_neg));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      if ($urandom_range(0, 19) == 0) r = r | (W'($urandom_range(10, 15)) << (4 * i));
      else                            r = r | (W'($urandom_range(0, 9)) << (4 * i));
    end
    return r;
  endfunction

  initial begin
    int seen_done;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);

    run_op(16'h0157, 16'h0042, 16'h0115, 1'b0, 1'b0, 4, 16'h0000, 1'b0);
    run_op(16'h0042, 16'h0157, 16'h0115, 1'b1, 1'b0, 8, 16'h9885, 1'b0);
    run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8, 16'h0001, 1'b0);
    run_op(16'h9999, 16'h0001, 16'h9998, 1'b0, 1'b0, 4, 16'h0000, 1'b0);
    run_op(16'h5050, 16'h5050, 16'h0000, 1'b0, 1'b0, 4, 16'h0000, 1'b0);
    run_op(16'h00A3, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 16'h0000, 1'b0);
    run_op(16'h0010, 16'h0003, 16'h0007, 1'b0, 1'b0, 4, 16'h0000, 1'b0);
    run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4, 16'h0000, 1'b1);

    // start asserted in the done cycle is accepted on the next edge
    @(posedge clk); #1;
    a = 16'h0300; b = 16'h0100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin seen_done = k; break; end
    end
    chk("b2b_first_lat", seen_done, 4);
    a = 16'h0005; b = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_second_diff", 32'(diff), 32'h0002);
    chk("b2b_second_neg", 32'(neg), 32'd1);

    // reset at cycle 2 of a negative op aborts without done
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_neg", 32'(neg), 32'd0);
    chk("abort_inv", 32'(invalid), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1;
    end
    chk("abort_no_done", seen_done, 0);
    run_op(16'h0001, 16'h0002, 16'h0001, 1'b1, 1'b0, 8, 16'h9999, 1'b0);

    // randomized starts, operands and occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a = rand_bcd();
      b = rand_bcd();
      reset = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
